// File: rtl/arm_shift_pkg.sv
// Shared types and constants for the iterative ARM register-specified shifter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arm_shift_pkg;

  // Shift operation selector
  typedef enum logic [1:0] {
    NO = 2'b00,  // pass through
    SL = 2'b01,  // logic shift left
    SR = 2'b10,  // shift right, arithmetic or logic
    RO = 2'b11   // rotate right
  } sw_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int         DATA_WIDTH_DEF = 33;
  // Beyond 33 single-bit steps, shift results no longer change.
  localparam logic [5:0] MAX_ITER       = 6'd33;

  // Number of single-bit steps needed for a request.
  function automatic logic [5:0] iter_count(input sw_t sw, input logic [7:0] amt);
    logic [5:0] n;
    n = '0;
    case (sw)
      SL, SR:  n = (amt >= 8'(MAX_ITER)) ? MAX_ITER : amt[5:0];
      RO:      n = {1'b0, amt[4:0]};
      default: n = '0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/arm_shift_32_step.sv
// One-bit shift/rotate step on a {carry, data[31:0]} word.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module arm_shift_32_step
  import arm_shift_pkg::*;
(
  input  logic [32:0] cd_in,
  input  sw_t         switch,
  input  logic        arith,
  output logic [32:0] cd_out
);

  // Carry takes the bit that leaves the word; fill depends on the operation.
  always_comb begin
    cd_out = cd_in;
    case (switch)
      SL:      cd_out = {cd_in[31], cd_in[30:0], 1'b0};
      SR:      cd_out = {cd_in[0], arith & cd_in[31], cd_in[31:1]};
      RO:      cd_out = {cd_in[0], cd_in[0], cd_in[31:1]};
      default: cd_out = cd_in;
    endcase
  end

endmodule

// File: rtl/arm_shift_32_seq.sv
// Iterative ARM shifter: one bit per cycle, result {carry_out, data[31:0]}.
// Latency: accept at T, result valid at T+1+n (n = 0..33 steps).
// Backpressure: accepts only in IDLE; result held in DONE until out_ready.
module arm_shift_32_seq
  import arm_shift_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            switch,
  input  logic                  arith,
  input  logic [7:0]            amount,
  input  logic [31:0]           data_in,
  input  logic                  carry_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] data_out
);

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  sw_t         sw_q;
  logic        arith_q;
  logic [32:0] work;
  logic [32:0] work_step;
  logic [32:0] res_q;
  logic [32:0] init_val;
  logic [5:0]  n_in;
  sw_t         sw_in;
  logic        accept;
  logic        last_step;

  assign sw_in     = sw_t'(switch);
  assign n_in      = iter_count(sw_in, amount);
  assign accept    = in_valid && in_ready;
  assign last_step = (state == SHIFT) && (cnt == 6'd1);

  // Rotate by a nonzero multiple of 32 leaves data intact but copies bit31 into carry.
  assign init_val = (sw_in == RO && amount != 8'd0 && amount[4:0] == 5'd0)
                    ? {data_in[31], data_in}
                    : {carry_in, data_in};

  arm_shift_32_step u_step (
    .cd_in  (work),
    .switch (sw_q),
    .arith  (arith_q),
    .cd_out (work_step)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = (n_in == 6'd0) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (cnt == 6'd1) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, step counter and result register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      sw_q    <= NO;
      arith_q <= 1'b0;
      work    <= '0;
      res_q   <= '0;
    end else if (accept) begin
      cnt     <= n_in;
      sw_q    <= sw_in;
      arith_q <= arith;
      work    <= init_val;
      if (n_in == 6'd0) res_q <= init_val;
    end else if (state == SHIFT) begin
      work <= work_step;
      cnt  <= cnt - 6'd1;
      if (last_step) res_q <= work_step;
    end
  end

  // res_q only changes on entry to DONE, so the output holds under backpressure.
  assign data_out = DATA_WIDTH'(res_q);

endmodule

// File: tb/tb_arm_shift_32_seq.sv
module tb_arm_shift_32_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  switch;
  logic        arith;
  logic [7:0]  amount;
  logic [31:0] data_in;
  logic        carry_in;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] data_out;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  sw;
    logic        ar;
    logic [7:0]  amt;
    logic [31:0] dat;
    logic        cin;
    int          lat;
    logic [32:0] exp;
  } vec_t;

  vec_t vecs[14];

  arm_shift_32_seq #(.DATA_WIDTH(33)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .switch    (switch),
    .arith     (arith),
    .amount    (amount),
    .data_in   (data_in),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int lat;
    lat = 0;
    while (!in_ready && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    switch   = v.sw;
    arith    = v.ar;
    amount   = v.amt;
    data_in  = v.dat;
    carry_in = v.cin;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    // Scramble inputs after acceptance: result must depend only on latched values.
    in_valid = 1'b0;
    switch   = ~v.sw;
    arith    = ~v.ar;
    amount   = ~v.amt;
    data_in  = ~v.dat;
    carry_in = ~v.cin;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 60);
    chk($sformatf("vec%0d latency", idx), 64'(lat), 64'(v.lat));
    chk($sformatf("vec%0d data_out", idx), 64'(data_out), 64'(v.exp));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got hang, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int seen;
    // sw, arith, amount, data, carry_in, latency, expected {carry, data}
    vecs[0]  = '{2'b01, 1'b0, 8'd4,   32'h8000_000F, 1'b0, 5,  {1'b0, 32'h0000_00F0}};
    vecs[1]  = '{2'b10, 1'b1, 8'd40,  32'h8000_0000, 1'b0, 34, {1'b1, 32'hFFFF_FFFF}};
    vecs[2]  = '{2'b10, 1'b0, 8'd40,  32'h8000_0000, 1'b0, 34, {1'b0, 32'h0000_0000}};
    vecs[3]  = '{2'b11, 1'b0, 8'd32,  32'h8000_0001, 1'b0, 1,  {1'b1, 32'h8000_0001}};
    vecs[4]  = '{2'b11, 1'b0, 8'd1,   32'h8000_0001, 1'b0, 2,  {1'b1, 32'hC000_0000}};
    vecs[5]  = '{2'b00, 1'b0, 8'd7,   32'h1234_5678, 1'b1, 1,  {1'b1, 32'h1234_5678}};
    vecs[6]  = '{2'b01, 1'b0, 8'd0,   32'hA5A5_A5A5, 1'b1, 1,  {1'b1, 32'hA5A5_A5A5}};
    vecs[7]  = '{2'b10, 1'b0, 8'd1,   32'h0000_0003, 1'b0, 2,  {1'b1, 32'h0000_0001}};
    vecs[8]  = '{2'b01, 1'b0, 8'd32,  32'h0000_0001, 1'b0, 33, {1'b1, 32'h0000_0000}};
    vecs[9]  = '{2'b01, 1'b0, 8'd33,  32'hFFFF_FFFF, 1'b1, 34, {1'b0, 32'h0000_0000}};
    vecs[10] = '{2'b11, 1'b0, 8'd36,  32'h0000_000F, 1'b0, 5,  {1'b1, 32'hF000_0000}};
    vecs[11] = '{2'b10, 1'b1, 8'd255, 32'h7FFF_FFFF, 1'b1, 34, {1'b0, 32'h0000_0000}};
    vecs[12] = '{2'b10, 1'b1, 8'd4,   32'h8000_0010, 1'b0, 5,  {1'b0, 32'hF800_0001}};
    vecs[13] = '{2'b11, 1'b0, 8'd33,  32'h0000_0002, 1'b1, 2,  {1'b0, 32'h0000_0001}};

    rst = 1'b1; in_valid = 1'b0; switch = 2'b00; arith = 1'b0; amount = 8'd0;
    data_in = 32'h0; carry_in = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset data_out", 64'(data_out), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Backpressure: result held, second request waits until after one bubble.
    @(negedge clk);
    switch = 2'b00; amount = 8'd7; data_in = 32'h1234_5678; carry_in = 1'b1;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    data_in = 32'hDEAD_BEEF; carry_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("hold%0d out_valid", k), 64'(out_valid), 64'd1);
      chk($sformatf("hold%0d in_ready", k), 64'(in_ready), 64'd0);
      chk($sformatf("hold%0d data_out", k), 64'(data_out), 64'({1'b1, 32'h1234_5678}));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bubble out_valid", 64'(out_valid), 64'd0);
    chk("bubble in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("second out_valid", 64'(out_valid), 64'd1);
    chk("second data_out", 64'(data_out), 64'({1'b0, 32'hDEAD_BEEF}));
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back with out_ready tied high.
    switch = 2'b00; amount = 8'd0; data_in = 32'h1111_1111; carry_in = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 data_in = 32'h2222_2222; carry_in = 1'b1;
    @(negedge clk);
    chk("b2b first out_valid", 64'(out_valid), 64'd1);
    chk("b2b first data_out", 64'(data_out), 64'({1'b0, 32'h1111_1111}));
    @(negedge clk);
    chk("b2b bubble in_ready", 64'(in_ready), 64'd1);
    chk("b2b bubble out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b second out_valid", 64'(out_valid), 64'd1);
    chk("b2b second data_out", 64'(data_out), 64'({1'b1, 32'h2222_2222}));
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("b2b idle in_ready", 64'(in_ready), 64'd1);

    // Reset in the middle of a 20-step left shift.
    switch = 2'b01; amount = 8'd20; data_in = 32'hFFFF_FFFF; carry_in = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre-reset in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid-shift reset in_ready", 64'(in_ready), 64'd1);
    chk("mid-shift reset out_valid", 64'(out_valid), 64'd0);
    chk("mid-shift reset data_out", 64'(data_out), 64'd0);
    out_ready = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("no stale result after reset", 64'(seen), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
